// File: rtl/palindrome_3bit.sv
// 3-bit palindrome detector: combinational flag for {a,b,c}, a registered copy,
// a saturating hit counter and a serial detector over the last three accepted bits.
module palindrome_3bit #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  output logic             y,
  output logic             y_q,
  output logic [CNT_W-1:0] pal_cnt,
  input  logic             s_in,
  input  logic             s_valid,
  output logic             s_y,
  output logic             s_y_valid
);

  function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [1:0] sat_inc_fill(input logic [1:0] v);
    return (v == 2'd3) ? v : v + 2'd1;
  endfunction

  logic             w_y_p0;
  logic [2:0]       w_hist_nxt_p0;
  logic [1:0]       w_fill_nxt_p0;
  logic             w_full_nxt_p0;

  logic             r_y_p1;
  logic [CNT_W-1:0] r_cnt_p1;
  logic [2:0]       r_hist_p1;
  logic [1:0]       r_fill_p1;
  logic             r_sy_p1;
  logic             r_syv_p1;

  // Stage p0: combinational flag; the centre bit is a don't-care and folds out.
  assign w_y_p0        = ~(a ^ c) & (b | ~b);
  assign w_hist_nxt_p0 = {r_hist_p1[1:0], s_in};
  assign w_fill_nxt_p0 = sat_inc_fill(r_fill_p1);
  assign w_full_nxt_p0 = (w_fill_nxt_p0 == 2'd3);

  // Stage p1: registered flag, hit counter and serial history.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_y_p1    <= 1'b0;
      r_cnt_p1  <= '0;
      r_hist_p1 <= 3'b000;
      r_fill_p1 <= 2'd0;
      r_sy_p1   <= 1'b0;
      r_syv_p1  <= 1'b0;
    end else begin
      r_y_p1 <= w_y_p0;
      if (w_y_p0) r_cnt_p1 <= sat_inc_cnt(r_cnt_p1);
      if (s_valid) begin
        r_hist_p1 <= w_hist_nxt_p0;
        r_fill_p1 <= w_fill_nxt_p0;
        r_sy_p1   <= (w_hist_nxt_p0[2] == w_hist_nxt_p0[0]) && w_full_nxt_p0;
        r_syv_p1  <= w_full_nxt_p0;
      end
    end
  end

  assign y         = w_y_p0;
  assign y_q       = r_y_p1;
  assign pal_cnt   = r_cnt_p1;
  assign s_y       = r_sy_p1;
  assign s_y_valid = r_syv_p1;

endmodule

// File: tb/tb_palindrome_3bit.sv
// Bench for palindrome_3bit: directed scenarios plus randomized traffic, all
// checked against a queue-based reference model of the palindrome rules.
module tb_palindrome_3bit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       a = 1'b0, b = 1'b0, c = 1'b0;
  logic       s_in = 1'b0, s_valid = 1'b0;

  logic       y, y_q, s_y, s_y_valid;
  logic [7:0] pal_cnt;
  logic       y2, y_q2, s_y2, s_y_valid2;
  logic [1:0] pal_cnt2;

  int passed = 0;
  int total  = 0;

  int   m_cnt, m_cnt2;
  logic m_yq, m_sy, m_syv;
  bit   q[$];

  palindrome_3bit #(.CNT_W(8)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .c(c),
    .y(y), .y_q(y_q), .pal_cnt(pal_cnt),
    .s_in(s_in), .s_valid(s_valid), .s_y(s_y), .s_y_valid(s_y_valid)
  );

  palindrome_3bit #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .a(a), .b(b), .c(c),
    .y(y2), .y_q(y_q2), .pal_cnt(pal_cnt2),
    .s_in(s_in), .s_valid(s_valid), .s_y(s_y2), .s_y_valid(s_y_valid2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Advance one edge, update the model from the inputs seen at that edge, compare.
  task automatic tick(input string tag);
    logic yv;
    @(posedge clk);
    yv = (a == c);
    if (rst) begin
      m_yq = 1'b0; m_cnt = 0; m_cnt2 = 0; m_sy = 1'b0; m_syv = 1'b0;
      q.delete();
    end else begin
      m_yq   = yv;
      m_cnt  = (m_cnt  + int'(yv) > 255) ? 255 : m_cnt  + int'(yv);
      m_cnt2 = (m_cnt2 + int'(yv) > 3)   ? 3   : m_cnt2 + int'(yv);
      if (s_valid) begin
        q.push_back(s_in);
        if (q.size() > 3) void'(q.pop_front());
        m_syv = (q.size() == 3);
        m_sy  = m_syv && (q[0] == q[2]);
      end
    end
    #1;
    chk({tag, ".y"},        32'(y),         32'(yv));
    chk({tag, ".y_q"},      32'(y_q),       32'(m_yq));
    chk({tag, ".pal_cnt"},  32'(pal_cnt),   32'(m_cnt));
    chk({tag, ".pal_cnt2"}, 32'(pal_cnt2),  32'(m_cnt2));
    chk({tag, ".s_y"},      32'(s_y),       32'(m_sy));
    chk({tag, ".s_y_vld"},  32'(s_y_valid), 32'(m_syv));
  endtask

  task automatic sbit(input logic v, input logic d, input string tag);
    s_valid = v; s_in = d;
    tick(tag);
  endtask

  logic [7:0] y_tab;
  int         sat_exp [6];
  logic [3:0] syv4, sy4, bits4;

  initial begin
    m_cnt = 0; m_cnt2 = 0; m_yq = 0; m_sy = 0; m_syv = 0;
    y_tab = 8'b1010_0101;
    sat_exp = '{1, 2, 3, 3, 3, 3};
    syv4 = 4'b0011; sy4 = 4'b0010; bits4 = 4'b1011;

    tick("reset0");
    chk("reset.y_q", 32'(y_q), 32'd0);
    chk("reset.pal_cnt", 32'(pal_cnt), 32'd0);
    chk("reset.s_y_valid", 32'(s_y_valid), 32'd0);

    // Exhaustive combinational sweep, held in reset so no state moves.
    for (int i = 0; i < 8; i++) begin
      {a, b, c} = 3'(i);
      #5;
      chk($sformatf("sweep%0d.y", i), 32'(y), 32'(y_tab[7-i]));
    end

    // Reset with a=c=1, then release.
    a = 1; b = 0; c = 1; rst = 1;
    #1 chk("rst.y_immediate", 32'(y), 32'd1);
    tick("rst_a"); chk("rst_a.y_q", 32'(y_q), 32'd0); chk("rst_a.cnt", 32'(pal_cnt), 32'd0);
    tick("rst_b"); chk("rst_b.y_q", 32'(y_q), 32'd0); chk("rst_b.cnt", 32'(pal_cnt), 32'd0);
    rst = 0;
    tick("rel");   chk("rel.y_q", 32'(y_q), 32'd1);   chk("rel.cnt", 32'(pal_cnt), 32'd1);

    // Saturation on the 2-bit counter instance.
    rst = 1; tick("sat_rst"); rst = 0;
    {a, b, c} = 3'b101;
    for (int i = 0; i < 6; i++) begin
      tick($sformatf("sat%0d", i));
      chk($sformatf("sat%0d.cnt2", i), 32'(pal_cnt2), 32'(sat_exp[i]));
    end
    {a, b, c} = 3'b100;
    tick("sat_hold"); chk("sat_hold.cnt2", 32'(pal_cnt2), 32'd3);

    // Serial 1,0,1 then 1.
    rst = 1; tick("ser_rst"); rst = 0;
    for (int i = 0; i < 4; i++) begin
      sbit(1'b1, bits4[3-i], $sformatf("ser%0d", i));
      chk($sformatf("ser%0d.syv", i), 32'(s_y_valid), 32'(syv4[3-i]));
      chk($sformatf("ser%0d.sy", i),  32'(s_y),       32'(sy4[3-i]));
    end

    // Serial 1,1, a three-cycle gap, then 1.
    rst = 1; s_valid = 0; tick("gap_rst"); rst = 0;
    sbit(1, 1, "gap_b0"); sbit(1, 1, "gap_b1");
    for (int i = 0; i < 3; i++) begin
      sbit(0, ~s_in, $sformatf("gap%0d", i));
      chk($sformatf("gap%0d.syv", i), 32'(s_y_valid), 32'd0);
    end
    sbit(1, 1, "gap_b2");
    chk("gap_end.sy", 32'(s_y), 32'd1); chk("gap_end.syv", 32'(s_y_valid), 32'd1);

    // Reset after 0,1,0; refill needs three new bits.
    rst = 1; s_valid = 0; tick("mid_rst0"); rst = 0;
    sbit(1, 0, "mid0"); sbit(1, 1, "mid1"); sbit(1, 0, "mid2");
    chk("mid2.sy", 32'(s_y), 32'd1);
    rst = 1; s_valid = 0; tick("mid_rst");
    chk("mid_rst.sy", 32'(s_y), 32'd0); chk("mid_rst.syv", 32'(s_y_valid), 32'd0);
    rst = 0;
    sbit(1, 1, "re0"); chk("re0.syv", 32'(s_y_valid), 32'd0);
    sbit(1, 0, "re1"); chk("re1.syv", 32'(s_y_valid), 32'd0);
    sbit(1, 1, "re2"); chk("re2.syv", 32'(s_y_valid), 32'd1); chk("re2.sy", 32'(s_y), 32'd1);

    // Randomized traffic against the model.
    s_valid = 0;
    for (int i = 0; i < 400; i++) begin
      {a, b, c} = 3'($urandom_range(0, 7));
      s_in      = 1'($urandom_range(0, 1));
      s_valid   = ($urandom_range(0, 3) != 0);
      rst       = ($urandom_range(0, 39) == 0);
      tick($sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
